// File: rtl/hex_scan_driver.sv
// hex_scan_driver: time-multiplexed driver for four common-anode/active-low
// 7-segment digits. Each digit owns a slot of CLK_DIV cycles. The last
// BLANK_CYC cycles of every slot blank all digits to prevent ghosting.
// New data is staged in a shadow register and promoted to the display
// register only at frame boundaries, so a frame is never torn.
module hex_scan_driver #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] DATA,
    input  logic        LOAD,
    input  logic        LZ_EN,
    output logic [3:0]  NIBBLE,
    output logic [3:0]  DIGIT_N,
    output logic        FRAME_TICK,
    output logic        PENDING
);

    // Reject parameter sets that leave no lit phase or no guard phase.
    if (!(BLANK_CYC >= 1 && CLK_DIV >= BLANK_CYC + 2)) begin : g_bad_params
        $error("hex_scan_driver: need BLANK_CYC>=1 and CLK_DIV>=BLANK_CYC+2");
    end

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] ON_LIM   = CW'(CLK_DIV - BLANK_CYC);

    // Scan state
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shd;
    logic [15:0]   dsp;
    logic          pend;
    // Clear while in reset; the first edge after release starts the scan
    // at digit 0, cnt 0 instead of advancing the counter.
    logic          run;

    // Next-state values
    logic [CW-1:0] cnt_n;
    logic [1:0]    idx_n;
    logic [15:0]   shd_n;
    logic [15:0]   dsp_n;
    logic          pend_n;
    logic          boundary;
    logic          on_phase;
    logic          suppressed;
    logic [3:0]    digit_n_n;
    logic [3:0]    nibble_n;
    logic [15:0]   upper;

    // Next-state and next-output computation; outputs are derived from the
    // state after the coming edge so they are registered yet not delayed.
    always_comb begin
        cnt_n      = cnt;
        idx_n      = idx;
        boundary   = 1'b0;
        shd_n      = shd;
        dsp_n      = dsp;
        pend_n     = pend;
        on_phase   = 1'b0;
        suppressed = 1'b0;
        digit_n_n  = 4'b1111;
        nibble_n   = NIBBLE;
        upper      = 16'd0;

        if (!run) begin
            cnt_n = '0;
            idx_n = 2'd0;
        end else if (cnt == CNT_LAST) begin
            cnt_n    = '0;
            idx_n    = idx + 2'd1;
            boundary = (idx == 2'd3);
        end else begin
            cnt_n = cnt + 1'b1;
        end

        // Promotion uses the pre-edge shadow; a coincident LOAD refills
        // the shadow and keeps pending set for the following frame.
        if (boundary && pend) begin
            dsp_n  = shd;
            pend_n = 1'b0;
        end
        if (LOAD) begin
            shd_n  = DATA;
            pend_n = 1'b1;
        end

        on_phase   = (cnt_n < ON_LIM);
        upper      = dsp_n >> {idx_n, 2'b00};
        suppressed = LZ_EN && (idx_n != 2'd0) && (upper == 16'd0);

        if (on_phase && !suppressed) begin
            digit_n_n = ~(4'b0001 << idx_n);
        end
        if (on_phase) begin
            nibble_n = dsp_n[{idx_n, 2'b00} +: 4];
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shd        <= 16'd0;
            dsp        <= 16'd0;
            pend       <= 1'b0;
            run        <= 1'b0;
            NIBBLE     <= 4'd0;
            DIGIT_N    <= 4'b1111;
            FRAME_TICK <= 1'b0;
            PENDING    <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            idx        <= idx_n;
            shd        <= shd_n;
            dsp        <= dsp_n;
            pend       <= pend_n;
            run        <= 1'b1;
            NIBBLE     <= nibble_n;
            DIGIT_N    <= digit_n_n;
            FRAME_TICK <= boundary;
            PENDING    <= pend_n;
        end
    end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot.
REQ-002 Parameter BLANK_CYC, default 16: anti-ghosting guard cycles at the end of each slot, all digits off.
REQ-003 CLK  input  1  rising-edge clock; the only clock.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 DATA  input  16  four-nibble value to display; nibble i drives digit i, digit 3 is most significant.
REQ-006 LOAD  input  1  single-cycle strobe; DATA is captured while LOAD=1.
REQ-007 LZ_EN  input  1  1 enables leading-zero suppression.
REQ-008 NIBBLE  output  4  hex code of the active digit; feeds the 7-segment decoder SW input.
REQ-009 DIGIT_N  output  4  digit enables, active-low one-hot; 4'b1111 means all digits off.
REQ-010 FRAME_TICK  output  1  one-cycle pulse at each frame boundary.
REQ-011 PENDING  output  1  1 while captured data is not yet on display.

Function
REQ-012 Elaboration SHALL fail unless BLANK_CYC>=1 and CLK_DIV>=BLANK_CYC+2.
REQ-013 Internal state: slot counter cnt (0..CLK_DIV-1), digit index idx (0..3), shadow register shd[15:0], display register dsp[15:0], pending flag.
REQ-014 All outputs SHALL be registers computed from next state, so outputs in cycle n reflect state after edge n.
REQ-015 cnt SHALL increment every cycle. At cnt=CLK_DIV-1, cnt wraps to 0 and idx advances; idx wraps 3->0.
REQ-016 Phase ON (cnt < CLK_DIV-BLANK_CYC): DIGIT_N bit idx SHALL be 0 and all other bits 1, unless the digit is suppressed. NIBBLE SHALL equal dsp[4*idx+3:4*idx].
REQ-017 Phase GUARD (remaining BLANK_CYC cycles): DIGIT_N SHALL be 4'b1111; NIBBLE holds its last value.
REQ-018 Suppression: with LZ_EN=1, digit idx>0 SHALL stay 4'b1111 for its whole slot when dsp nibbles idx..3 are all zero. Digit 0 is never suppressed.
REQ-019 LZ_EN SHALL be sampled every cycle; a change takes effect on the next cycle.
REQ-020 LOAD=1: shd<=DATA and pending<=1 on the same edge. Multiple LOADs within a frame: the last one wins.
REQ-021 Frame boundary (cnt=CLK_DIV-1 and idx=3):
  - FRAME_TICK=1 for exactly one cycle, aligned with the first cycle of digit 0.
  - If pending=1, dsp<=shd and pending clears.
REQ-022 LOAD coincident with a frame boundary:
  - dsp SHALL take the pre-edge shd.
  - shd SHALL take the new DATA.
  - pending SHALL remain 1.
REQ-023 dsp SHALL change only at frame boundaries, so no torn frames occur.
REQ-024 PENDING SHALL mirror the pending flag.

Reset
REQ-025 While RST=1: cnt=0, idx=0, shd=0, dsp=0, pending=0, DIGIT_N=4'b1111, NIBBLE=0, FRAME_TICK=0, PENDING=0. LOAD is ignored.
REQ-026 On the first edge with RST=0, scanning SHALL start at digit 0, cnt=0, giving DIGIT_N=4'b1110 and NIBBLE=0.
REQ-027 RST asserted mid-slot or mid-frame SHALL abandon the scan; the next edge applies REQ-025 values, and captured but undisplayed data is lost.

Verification (CLK_DIV=8, BLANK_CYC=2, LZ_EN=0 unless stated)
REQ-028 Reset release, LOAD DATA=16'h1234 in cycle 3:
  - PENDING=1 from cycle 4.
  - Frame 1 shows 0 on all digits.
  - FRAME_TICK fires at cycle 33; PENDING=0 from then on.
  - Frame 2 per digit: DIGIT_N 1110/NIBBLE 4, then 1101/3, 1011/2, 0111/1; each digit lit 6 cycles, then 1111 for 2 cycles.
REQ-029 LZ_EN=1, dsp=16'h0050:
  - Digits 3 and 2 stay 1111 for their full slots.
  - Digit 1 shows 5; digit 0 shows 0.
  - dsp=16'h0000: only digit 0 lights, NIBBLE 0.
REQ-030 Two LOADs (16'hAAAA then 16'hBBBB) within one frame: the next frame shows B on all digits and never shows A.
REQ-031 LOAD 16'hCDEF on the frame-boundary cycle while shd=16'h1111 is pending:
  - Next frame shows 1111.
  - PENDING stays 1.
  - The following frame shows CDEF.
REQ-032 RST pulsed during digit 2 ON phase:
  - Next cycle: DIGIT_N=1111, all state zero.
  - After release: digit 0 lit with NIBBLE 0.
  - FRAME_TICK 32 cycles later.
